// File: rtl/ccff_bitstream_loader.sv
// Bitstream loader for a configuration chain: serializes valid/ready words MSB-first
// onto ccff_head. Optional readback pass enabled by `define CCFF_LOADER_READBACK_EN.
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 32,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count
);
  localparam int NB_W = $clog2(WORD_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
`ifdef CCFF_LOADER_READBACK_EN
    S_VERIFY,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [NB_W-1:0]   nbits_q, nbits_d, nbits_load;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d, remaining;
  state_t            last_word_next;

`ifdef CCFF_LOADER_READBACK_EN
  logic [CHAIN_LEN-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]     vcnt_q, vcnt_d;
  logic                 error_q, error_d;
  assign last_word_next = S_VERIFY;
  assign error          = error_q;
`else
  logic unused_tail;
  assign unused_tail    = ccff_tail;
  assign last_word_next = S_DONE;
  assign error          = 1'b0;
`endif

  // The final word may be partial; only the bits still owed to the chain are shifted.
  assign remaining  = CNT_W'(CHAIN_LEN) - bit_count_q;
  assign nbits_load = (remaining >= CNT_W'(WORD_W)) ? NB_W'(WORD_W) : remaining[NB_W-1:0];
  assign bit_count  = bit_count_q;

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    nbits_d     = nbits_q;
    bit_count_d = bit_count_q;
    s_ready     = 1'b0;
    ccff_head   = 1'b0;
    ccff_clk_en = 1'b0;
    done        = 1'b0;
    busy        = (state_q != S_IDLE);
`ifdef CCFF_LOADER_READBACK_EN
    shadow_d    = shadow_q;
    vcnt_d      = vcnt_q;
    error_d     = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          bit_count_d = '0;
`ifdef CCFF_LOADER_READBACK_EN
          error_d     = 1'b0;
`endif
        end
      end
      S_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          sreg_d  = s_data;
          nbits_d = nbits_load;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        ccff_clk_en = 1'b1;
        ccff_head   = sreg_q[WORD_W-1];
        sreg_d      = sreg_q << 1;
        bit_count_d = bit_count_q + 1'b1;
        nbits_d     = nbits_q - 1'b1;
`ifdef CCFF_LOADER_READBACK_EN
        shadow_d    = (shadow_q << 1) | CHAIN_LEN'(sreg_q[WORD_W-1]);
        vcnt_d      = '0;
`endif
        if (nbits_q == NB_W'(1)) begin
          state_d = (bit_count_q == CNT_W'(CHAIN_LEN - 1)) ? last_word_next : S_LOAD;
        end
      end
`ifdef CCFF_LOADER_READBACK_EN
      // Feeding tail back to head rotates the chain once, leaving its contents intact.
      S_VERIFY: begin
        ccff_clk_en = 1'b1;
        ccff_head   = ccff_tail;
        if (ccff_tail != shadow_q[CHAIN_LEN-1]) error_d = 1'b1;
        shadow_d    = (shadow_q << 1) | CHAIN_LEN'(shadow_q[CHAIN_LEN-1]);
        vcnt_d      = vcnt_q + 1'b1;
        if (vcnt_q == CNT_W'(CHAIN_LEN - 1)) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      nbits_q     <= '0;
      bit_count_q <= '0;
`ifdef CCFF_LOADER_READBACK_EN
      shadow_q    <= '0;
      vcnt_q      <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      nbits_q     <= nbits_d;
      bit_count_q <= bit_count_d;
`ifdef CCFF_LOADER_READBACK_EN
      shadow_q    <= shadow_d;
      vcnt_q      <= vcnt_d;
      error_q     <= error_d;
`endif
    end
  end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: scoreboarded head bits, timing, back-pressure,
// partial word, reset, ignored start, and readback when CCFF_LOADER_READBACK_EN is defined.
module tb_ccff_bitstream_loader;
`ifdef CCFF_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk, rst_n, start, s_valid, sel, fault;
  logic [7:0] s_data;
  logic start_a, start_b, valid_a, valid_b;
  logic rdy_a, head_a, en_a, busy_a, done_a, err_a;
  logic rdy_b, head_b, en_b, busy_b, done_b, err_b;
  logic [15:0] bc_a, bc_b;
  logic [31:0] chain_a = '0;
  logic [19:0] chain_b = '0;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign valid_a = s_valid & ~sel;
  assign valid_b = s_valid & sel;

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(32), .CNT_W(16)) dut_a (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_a), .s_data(s_data),
    .s_valid(valid_a), .s_ready(rdy_a), .ccff_head(head_a), .ccff_clk_en(en_a),
    .ccff_tail(chain_a[31]), .busy(busy_a), .done(done_a), .error(err_a), .bit_count(bc_a));

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(16)) dut_b (
    .prog_clk(clk), .prog_reset_n(rst_n), .start(start_b), .s_data(s_data),
    .s_valid(valid_b), .s_ready(rdy_b), .ccff_head(head_b), .ccff_clk_en(en_b),
    .ccff_tail(chain_b[19]), .busy(busy_b), .done(done_b), .error(err_b), .bit_count(bc_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Chain models; fault inverts the output of flop 10 of the 32-flop chain.
  always @(posedge clk) begin
    if (en_a) begin
      chain_a <= {chain_a[30:0], head_a};
      if (fault) chain_a[11] <= ~chain_a[10];
    end
    if (en_b) chain_b <= {chain_b[18:0], head_b};
  end

  logic rdy_m, head_m, en_m, busy_m, done_m, err_m;
  logic [15:0] bc_m;
  assign rdy_m  = sel ? rdy_b  : rdy_a;
  assign head_m = sel ? head_b : head_a;
  assign en_m   = sel ? en_b   : en_a;
  assign busy_m = sel ? busy_b : busy_a;
  assign done_m = sel ? done_b : done_a;
  assign err_m  = sel ? err_b  : err_a;
  assign bc_m   = sel ? bc_b   : bc_a;

  int checks = 0, failures = 0;
  int cyc = 0, t0 = 0, en_cnt = 0, done_cnt = 0, done_cyc = 0, exp_len = 32, pushed = 0;
  logic [15:0] bc_at_done;
  logic err_at_done;
  logic exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the falling edge, then score whatever the active DUT produced.
  task automatic tick();
    logic e;
    @(negedge clk);
    cyc++;
    if (en_m) begin
      en_cnt++;
      if (en_cnt <= exp_len) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          failures++;
          $error("FAIL sb_underrun observed=enabled expected=no_enable");
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("head_bit", head_m, e);
        end
      end
    end
    if (done_m) begin
      done_cnt++;
      done_cyc    = cyc - t0;
      bc_at_done  = bc_m;
      err_at_done = err_m;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    t0 = cyc; en_cnt = 0; done_cnt = 0; pushed = 0;
    exp_q.delete();
    tick();
    start = 1'b0;
    chk("load_ready", rdy_m, 1'b1);
    chk("err_clear_on_start", err_m, 1'b0);
    chk("bc_clear_on_start", bc_m, 16'd0);
  endtask

  task automatic send_word(input logic [7:0] d, input int gap, input bit pulse);
    int w, nb;
    w = 0;
    while (!rdy_m && w < 200) begin tick(); w++; end
    chk("ready_wait", rdy_m, 1'b1);
    s_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      start = pulse && (i == 0);
      tick();
      chk("gap_ready", rdy_m, 1'b1);
      chk("gap_clk_en", en_m, 1'b0);
    end
    start = 1'b0;
    nb = ((exp_len - pushed) < 8) ? (exp_len - pushed) : 8;
    for (int b = 0; b < nb; b++) exp_q.push_back(d[7-b]);
    pushed += nb;
    s_data = d; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic run_load(input bit which, input logic [31:0] words, input int nw,
                          input int gap, input bit pulse);
    int w, base;
    sel = which;
    exp_len = which ? 20 : 32;
    base = which ? (RB ? 44 : 24) : (RB ? 69 : 37);
    do_start();
    for (int i = 0; i < nw; i++) begin
      send_word(words[31-8*i -: 8], (i == 1) ? gap : 0, pulse && (i == 1));
      if (pulse && i == 0) begin
        start = 1'b1; tick(); start = 1'b0;
      end
    end
    w = 0;
    while (done_cnt == 0 && w < 300) begin tick(); w++; end
    chk("done_seen", done_cnt, 1);
    chk("done_cycle", done_cyc, base + gap);
    chk("bc_at_done", bc_at_done, exp_len);
    chk("sb_empty", exp_q.size(), 0);
    chk("busy_at_done", busy_m, 1'b1);
    tick();
    chk("busy_after_done", busy_m, 1'b0);
    chk("en_count", en_cnt, RB ? 2 * exp_len : exp_len);
    repeat (4) tick();
    chk("single_done", done_cnt, 1);
    chk("idle_clk_en", en_m, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; sel = 1'b0; fault = 1'b0;
    tick(); tick();
    chk("rst_ready", rdy_a, 1'b0);
    chk("rst_head", head_a, 1'b0);
    chk("rst_clk_en", en_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_error", err_a, 1'b0);
    chk("rst_bc", bc_a, 16'd0);
    chk("rst_bc_b", bc_b, 16'd0);
    rst_n = 1'b1;
    tick();

    run_load(1'b0, 32'hA53CFF01, 4, 0, 1'b0);
    chk("full_err", err_at_done, 1'b0);
    chk("full_chain", chain_a, 32'hA53CFF01);

    run_load(1'b0, 32'hA53CFF01, 4, 5, 1'b0);
    chk("bp_chain", chain_a, 32'hA53CFF01);

    run_load(1'b1, 32'hFF00F000, 3, 0, 1'b0);
    chk("partial_err", err_at_done, 1'b0);
    chk("partial_chain", chain_b, 20'hFF00F);

    run_load(1'b0, 32'h5AC3_0F96, 4, 2, 1'b1);
    chk("ignored_start_chain", chain_a, 32'h5AC30F96);

`ifdef CCFF_LOADER_READBACK_EN
    fault = 1'b1;
    run_load(1'b0, 32'hA53CFF01, 4, 0, 1'b0);
    chk("rb_err_at_done", err_at_done, 1'b1);
    chk("rb_err_sticky", err_a, 1'b1);
    fault = 1'b0;
    run_load(1'b0, 32'h1234_5678, 4, 0, 1'b0);
    chk("rb_err_clean", err_at_done, 1'b0);
    chk("rb_chain", chain_a, 32'h12345678);
`endif

    sel = 1'b0; exp_len = 32;
    do_start();
    send_word(8'hC3, 0, 1'b0);
    while ((cyc - t0) < 5) tick();
    chk("pre_rst_clk_en", en_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clk_en", en_a, 1'b0);
    chk("arst_head", head_a, 1'b0);
    chk("arst_busy", busy_a, 1'b0);
    chk("arst_ready", rdy_a, 1'b0);
    chk("arst_bc", bc_a, 16'd0);
    tick(); tick();
    rst_n = 1'b1;
    exp_q.delete();
    tick();
    run_load(1'b0, 32'hA53CFF01, 4, 0, 1'b0);
    chk("post_rst_chain", chain_a, 32'hA53CFF01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
